// File: rtl/serial_subtractor_8bit_pkg.sv
// ---------------------------------------------------------------------------
// serial_subtractor_8bit_pkg
//
// Purpose: shared definitions for the bit-serial subtractor.
//   - DEFAULT_WIDTH : default operand/result width
//   - state_t       : FSM state encoding (IDLE / RUN / DONE)
//   - cntWidth()    : bit counter width for a given operand width
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package serial_subtractor_8bit_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter only has to reach WIDTH-1. At least one bit is always kept,
  // so the counter never collapses to zero width.
  function automatic int cntWidth(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_8bit_subtractor_1bit.sv
// ---------------------------------------------------------------------------
// subtractor_1bit
//
// Purpose: combinational full subtractor. It computes x - y - bin for one bit.
//
// Ports:
//   x    : minuend bit
//   y    : subtrahend bit
//   bin  : borrow in from the less significant bit
//   d    : difference bit
//   bout : borrow out to the more significant bit
// ---------------------------------------------------------------------------
module subtractor_1bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // A borrow is generated when x=0 and y=1. When x equals y, the incoming
  // borrow passes through to bout.
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor_8bit.sv
// ---------------------------------------------------------------------------
// serial_subtractor_8bit
//
// Purpose: bit-serial two's-complement subtractor. It computes
// diff = a - b - borrow_in over WIDTH clock cycles, LSB first. A single
// full-subtractor cell is reused on every cycle. Results stay registered
// until the next operation completes.
//
// Optional feature macro: SERIAL_SUB_OVF_EN
//   - When defined, the block computes a signed overflow flag from the
//     captured operand sign bits.
//   - When undefined, overflow is tied to 0.
//
// Parameters:
//   WIDTH      : operand/result width (2..32)
//
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : operation request
//   a, b       : minuend / subtrahend, captured on accept
//   borrow_in  : initial borrow, captured on accept
//   busy       : high while the operation is running
//   done       : one-cycle pulse when the result is valid
//   diff       : registered result
//   borrow_out : final borrow (1 = unsigned a < b + borrow_in)
//   overflow   : signed overflow flag
// ---------------------------------------------------------------------------
module serial_subtractor_8bit
  import serial_subtractor_8bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int                CNT_W    = cntWidth(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_aShift;
  logic [WIDTH-1:0] r_bShift;
  logic [WIDTH-2:0] r_dShift;
  logic [WIDTH-1:0] r_diff;
  logic [WIDTH-1:0] w_shiftIn;
  logic [CNT_W-1:0] r_count;
  logic             r_borrow;
  logic             r_borrowOut;
  logic             w_accept;
  logic             w_lastBit;
  logic             w_d;
  logic             w_bout;

  // A start request is accepted in IDLE, and also in DONE so that
  // operations can run back to back.
  assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_lastBit = (r_state == RUN) && (r_count == LAST_BIT);

  // r_dShift holds the difference bits produced so far, with the newest bit
  // at the top. Adding the current bit gives the full result on the last
  // cycle.
  assign w_shiftIn = {w_d, r_dShift};

  subtractor_1bit u_sub (
    .x   (r_aShift[0]),
    .y   (r_bShift[0]),
    .bin (r_borrow),
    .d   (w_d),
    .bout(w_bout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. DONE lasts one cycle unless a new start arrives.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    w_nextState = start ? RUN : IDLE;
      RUN:     w_nextState = (r_count == LAST_BIT) ? DONE : RUN;
      DONE:    w_nextState = start ? RUN : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Handshake outputs are decoded directly from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Serial datapath:
  //   - Operands shift right, so bit 0 is always the bit being processed.
  //   - The output registers update only on the final bit. Partial results
  //     never reach diff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aShift    <= '0;
      r_bShift    <= '0;
      r_dShift    <= '0;
      r_diff      <= '0;
      r_count     <= '0;
      r_borrow    <= 1'b0;
      r_borrowOut <= 1'b0;
    end else if (w_accept) begin
      r_aShift <= a;
      r_bShift <= b;
      r_borrow <= borrow_in;
      r_count  <= '0;
    end else if (r_state == RUN) begin
      r_aShift <= r_aShift >> 1;
      r_bShift <= r_bShift >> 1;
      r_dShift <= w_shiftIn[WIDTH-1:1];
      r_borrow <= w_bout;
      r_count  <= r_count + CNT_W'(1);
      if (w_lastBit) begin
        r_diff      <= w_shiftIn;
        r_borrowOut <= w_bout;
      end
    end
  end

  assign diff       = r_diff;
  assign borrow_out = r_borrowOut;

`ifdef SERIAL_SUB_OVF_EN
  logic r_aSign;
  logic r_bSign;
  logic r_overflow;

  // Overflow occurs when the operand signs differ and the result sign
  // differs from the minuend sign. The sign bits are captured on accept
  // because the inputs may change during the run. The flag updates together
  // with diff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aSign    <= 1'b0;
      r_bSign    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_aSign <= a[WIDTH-1];
      r_bSign <= b[WIDTH-1];
    end else if (w_lastBit) begin
      r_overflow <= (r_aSign != r_bSign) && (w_d != r_aSign);
    end
  end

  assign overflow = r_overflow;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor_8bit.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor_8bit
//
// Purpose: self-checking bench for serial_subtractor_8bit (WIDTH=8).
//   - A behavioural model of the handshake pushes the expected result onto a
//     scoreboard when it accepts a start request.
//   - The model pops that result when the operation should complete.
//   - On every falling edge the bench compares the DUT outputs with the
//     model.
//
// Optional feature macro honoured: SERIAL_SUB_OVF_EN
// ---------------------------------------------------------------------------
module tb_serial_subtractor_8bit;

  typedef struct {
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
  } expected_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       borrowIn;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrowOut;
  logic       overflow;

  int checkCount = 0;
  int failCount  = 0;

  // Model state: 0 = idle, 1 = running, 2 = result cycle.
  int         mState    = 0;
  int         mCnt      = 0;
  logic [7:0] expDiff   = 8'h00;
  logic       expBorrow = 1'b0;
  logic       expOvf    = 1'b0;
  expected_t  scoreboard[$];

  serial_subtractor_8bit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .borrow_in (borrowIn),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow_out(borrowOut),
    .overflow  (overflow)
  );

  // 10-time-unit clock. Inputs change on the falling edge, well away from
  // the rising edge where they are sampled.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic. A 9-bit subtraction places the borrow in bit 8.
  function automatic expected_t calcExpected(input logic [7:0] aV,
                                             input logic [7:0] bV,
                                             input logic       binV);
    expected_t  e;
    logic [8:0] wide;
    wide     = {1'b0, aV} - {1'b0, bV} - {8'b0, binV};
    e.diff   = wide[7:0];
    e.borrow = wide[8];
`ifdef SERIAL_SUB_OVF_EN
    e.ovf = (aV[7] != bV[7]) && (wide[7] != aV[7]);
`else
    e.ovf = 1'b0;
`endif
    return e;
  endfunction

  // Handshake model:
  //   - Accept a request in idle or in the result cycle.
  //   - Run for 8 edges, then publish the result popped from the scoreboard.
  //   - Reset drops anything still in flight.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mState    <= 0;
      mCnt      <= 0;
      expDiff   <= 8'h00;
      expBorrow <= 1'b0;
      expOvf    <= 1'b0;
      scoreboard.delete();
    end else begin
      case (mState)
        1: begin
          if (mCnt == 7) begin
            mState    <= 2;
            expDiff   <= scoreboard[0].diff;
            expBorrow <= scoreboard[0].borrow;
            expOvf    <= scoreboard[0].ovf;
            scoreboard.pop_front();
          end else begin
            mCnt <= mCnt + 1;
          end
        end
        default: begin
          if (start) begin
            scoreboard.push_back(calcExpected(a, b, borrowIn));
            mState <= 1;
            mCnt   <= 0;
          end else begin
            mState <= 0;
          end
        end
      endcase
    end
  end

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h at t=%0t",
               tag, observed, expected, $time);
    end
  endtask

  // Compares every output on every falling edge. The per-cycle diff check
  // also confirms that results hold between completions.
  task automatic monitorOutputs();
    forever begin
      @(negedge clk);
      checkOutput("busy",       busy,      mState == 1);
      checkOutput("done",       done,      mState == 2);
      checkOutput("diff",       diff,      expDiff);
      checkOutput("borrow_out", borrowOut, expBorrow);
      checkOutput("overflow",   overflow,  expOvf);
    end
  endtask

  // Drives a one-cycle start pulse with the given operands.
  task automatic applyStimulus(input logic [7:0] aV, input logic [7:0] bV,
                               input logic binV);
    @(negedge clk);
    a        = aV;
    b        = bV;
    borrowIn = binV;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    start    = 1'b0;
    a        = 8'h00;
    b        = 8'h00;
    borrowIn = 1'b0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_busy", busy,      0);
    checkOutput("reset_diff", diff,      0);
    checkOutput("reset_done", done,      0);
    fork
      monitorOutputs();
    join_none
    idleCycles(2);
    rst_n = 1'b1;
    idleCycles(2);

    $display("[TB] basic subtract");
    applyStimulus(8'h50, 8'h20, 1'b0);
    idleCycles(10);

    $display("[TB] underflow and borrow-in");
    applyStimulus(8'h20, 8'h50, 1'b0);
    idleCycles(9);
    applyStimulus(8'h00, 8'h00, 1'b1);
    idleCycles(9);
    applyStimulus(8'h00, 8'h01, 1'b0);
    idleCycles(9);
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    idleCycles(9);

    $display("[TB] signed overflow cases");
    applyStimulus(8'h80, 8'h01, 1'b0);
    idleCycles(9);
    applyStimulus(8'h05, 8'h03, 1'b0);
    idleCycles(9);
    applyStimulus(8'h7F, 8'hFF, 1'b0);
    idleCycles(9);

    $display("[TB] random operands");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)));
      idleCycles(9);
    end

    $display("[TB] start held high, back-to-back");
    @(negedge clk);
    a        = 8'h10;
    b        = 8'h01;
    borrowIn = 1'b0;
    start    = 1'b1;
    idleCycles(20);
    start = 1'b0;
    idleCycles(10);

    $display("[TB] start during run is ignored");
    applyStimulus(8'h10, 8'h01, 1'b0);
    idleCycles(2);
    a        = 8'h99;
    b        = 8'h22;
    borrowIn = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idleCycles(9);

    $display("[TB] inputs change after accept, result held while idle");
    @(negedge clk);
    a        = 8'h10;
    b        = 8'h01;
    borrowIn = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    a        = 8'hAA;
    b        = 8'h55;
    borrowIn = 1'b1;
    idleCycles(19);

    $display("[TB] reset mid-operation");
    applyStimulus(8'h40, 8'h01, 1'b0);
    idleCycles(3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy",       busy,      0);
    checkOutput("abort_done",       done,      0);
    checkOutput("abort_diff",       diff,      0);
    checkOutput("abort_borrow_out", borrowOut, 0);
    checkOutput("abort_overflow",   overflow,  0);
    idleCycles(2);
    rst_n = 1'b1;
    idleCycles(3);
    applyStimulus(8'h03, 8'h01, 1'b0);
    idleCycles(12);

    checkOutput("scoreboard_empty", scoreboard.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
